// File: rtl/dram_sequencer.sv
// dram_sequencer: RAS/CAS/WE sequencing, row/column address mux, refresh timer and refresh arbitration.
// Optional build macro REFRESH_DEFER_EN lets CPU accesses defer up to four pending refreshes.

module dram_sequencer #(
   parameter int REFRESH_INTERVAL = 110,
   parameter int PRECHARGE_CYCLES = 2,
   parameter int REF_RAS_CYCLES   = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [23:1] ADDR,
   input  logic        AS_n,
   input  logic        UDS_n,
   input  logic        LDS_n,
   input  logic        RW,
   input  logic        ram_access,
   output logic [10:0] MA,
   output logic        RAS_n,
   output logic [1:0]  CAS_n,
   output logic        WE_n,
   output logic        dtack,
   output logic        refresh_busy
);

   typedef enum logic [2:0] {
      IDLE, ACC_RAS, ACC_CAS, ACC_HOLD, PRECHARGE, REF_CAS, REF_RAS
   } state_t;

`ifdef REFRESH_DEFER_EN
   localparam int PW = 3;
   localparam logic [PW-1:0] PMAX = 3'd4;
`else
   localparam int PW = 1;
   localparam logic [PW-1:0] PMAX = 1'b1;
`endif
   localparam logic [PW-1:0] PONE     = PW'(1);
   localparam logic [9:0]    RELOAD   = 10'(REFRESH_INTERVAL - 1);
   localparam logic [2:0]    PRE_LOAD = 3'(PRECHARGE_CYCLES - 1);
   localparam logic [2:0]    RAS_LOAD = 3'(REF_RAS_CYCLES - 1);

   state_t        state, next;
   logic [2:0]    cnt, cnt_d;
   logic [9:0]    timer;
   logic [PW-1:0] pending, pending_d;
   logic          tick, req, want, grant, start;
   logic [10:0]   row, col, ma_d;
   logic          ras_d, we_d, dtack_d, busy_d;
   logic [1:0]    cas_d;
   logic          unused_addr;

   assign unused_addr = ADDR[23];
   assign row   = ADDR[22:12];
   assign col   = ADDR[11:1];
   assign tick  = (timer == 10'd0);
   assign req   = ram_access & ~AS_n & (~UDS_n | ~LDS_n);
   // A tick on the IDLE edge counts as a request even before it reaches pending.
   assign want  = (pending != '0) | tick;
`ifdef REFRESH_DEFER_EN
   assign grant = (pending == PMAX) | (want & ~req);
`else
   assign grant = want;
`endif
   assign start = (state == IDLE) && grant;

   always_comb begin
      pending_d = pending;
      if (tick && !start) begin
         if (pending != PMAX) pending_d = pending + PONE;
      end else if (start && !tick) begin
         pending_d = pending - PONE;
      end
   end

   always_comb begin
      next  = state;
      cnt_d = (cnt != 3'd0) ? cnt - 3'd1 : cnt;
      case (state)
         IDLE:      if (grant) next = REF_CAS; else if (req) next = ACC_RAS;
         ACC_RAS:   next = AS_n ? PRECHARGE : ACC_CAS;
         ACC_CAS:   next = AS_n ? PRECHARGE : ACC_HOLD;
         ACC_HOLD:  if (AS_n) next = PRECHARGE;
         REF_CAS:   next = REF_RAS;
         REF_RAS:   if (cnt == 3'd0) next = PRECHARGE;
         PRECHARGE: if (cnt == 3'd0) next = IDLE;
         default:   next = IDLE;
      endcase
      if (next == REF_RAS && state != REF_RAS) cnt_d = RAS_LOAD;
      if (next == PRECHARGE && state != PRECHARGE) cnt_d = PRE_LOAD;

      // Outputs are decoded from the next state so every pin is a flop.
      ras_d   = 1'b1;
      cas_d   = 2'b11;
      we_d    = 1'b1;
      ma_d    = row;
      dtack_d = 1'b0;
      busy_d  = 1'b0;
      case (next)
         ACC_RAS: begin
            ras_d = 1'b0;
            we_d  = RW;
         end
         ACC_CAS: begin
            ras_d = 1'b0;
            we_d  = WE_n;
            cas_d = {UDS_n, LDS_n};
            ma_d  = col;
         end
         ACC_HOLD: begin
            ras_d   = 1'b0;
            we_d    = WE_n;
            cas_d   = CAS_n;
            ma_d    = col;
            dtack_d = 1'b1;
         end
         REF_CAS: begin
            cas_d  = 2'b00;
            busy_d = 1'b1;
         end
         REF_RAS: begin
            ras_d  = 1'b0;
            cas_d  = 2'b00;
            busy_d = 1'b1;
         end
         PRECHARGE: busy_d = (state == REF_RAS) || (state == PRECHARGE && refresh_busy);
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= IDLE;
         cnt          <= 3'd0;
         timer        <= RELOAD;
         pending      <= '0;
         MA           <= 11'd0;
         RAS_n        <= 1'b1;
         CAS_n        <= 2'b11;
         WE_n         <= 1'b1;
         dtack        <= 1'b0;
         refresh_busy <= 1'b0;
      end else begin
         state        <= next;
         cnt          <= cnt_d;
         timer        <= tick ? RELOAD : timer - 10'd1;
         pending      <= pending_d;
         MA           <= ma_d;
         RAS_n        <= ras_d;
         CAS_n        <= cas_d;
         WE_n         <= we_d;
         dtack        <= dtack_d;
         refresh_busy <= busy_d;
      end
   end

endmodule
